// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared video timing types, 640x480@60 defaults and frame-size helpers
package video_pkg;

  typedef enum logic {
    POL_LOW  = 1'b0,
    POL_HIGH = 1'b1
  } sync_pol_e;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
  } timing_t;

  localparam timing_t VGA_640X480 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
  };

  function automatic int unsigned h_total(input timing_t t);
    return t.h_active + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic int unsigned v_total(input timing_t t);
    return t.v_active + t.v_fp + t.v_sync + t.v_bp;
  endfunction

endpackage

// File: rtl/pix_clk_div.sv
// rtl/pix_clk_div.sv - divides clk_i into a one-cycle pixel enable every CLK_DIV clocks
module pix_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tick,
  output logic o_pix_ce
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_pix_ce;

  // o_tick is the combinational "this edge presents a new pixel"; r_pix_ce is its registered twin
  assign o_tick   = i_en && (r_div == '0);
  assign o_pix_ce = r_pix_ce;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div    <= '0;
      r_pix_ce <= 1'b0;
    end else if (!i_en) begin
      r_div    <= '0;
      r_pix_ce <= 1'b0;
    end else begin
      r_div    <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      r_pix_ce <= (r_div == '0);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator: syncs, DE, coordinates, prefetch, vblank IRQ
module video_timing_gen
  import video_pkg::*;
#(
  parameter int        H_ACTIVE   = int'(VGA_640X480.h_active),
  parameter int        H_FP       = int'(VGA_640X480.h_fp),
  parameter int        H_SYNC     = int'(VGA_640X480.h_sync),
  parameter int        H_BP       = int'(VGA_640X480.h_bp),
  parameter int        V_ACTIVE   = int'(VGA_640X480.v_active),
  parameter int        V_FP       = int'(VGA_640X480.v_fp),
  parameter int        V_SYNC     = int'(VGA_640X480.v_sync),
  parameter int        V_BP       = int'(VGA_640X480.v_bp),
  parameter sync_pol_e HS_POL     = POL_LOW,
  parameter sync_pol_e VS_POL     = POL_LOW,
  parameter int        CLK_DIV    = 4,
  parameter int        FETCH_LEAD = 32,
  parameter int        CNT_W      = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             irq_clr_i,
  output logic             pix_ce_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             de_o,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic             line_start_o,
  output logic             frame_start_o,
  output logic             line_req_o,
  output logic [CNT_W-1:0] line_req_y_o,
  output logic             vblank_irq_o,
  output logic [15:0]      frame_cnt_o
);

  localparam timing_t TIMING = '{
    h_active: H_ACTIVE, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
    v_active: V_ACTIVE, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP
  };
  localparam int H_TOTAL = int'(h_total(TIMING));
  localparam int V_TOTAL = int'(v_total(TIMING));

  if (H_ACTIVE == 0 || V_ACTIVE == 0 || H_TOTAL == 0 || V_TOTAL == 0) begin : g_bad_size
    $error("video_timing_gen: active area and totals must be non-zero");
  end
  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_cnt_w
    $error("video_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
  end
  if (FETCH_LEAD < 1 || FETCH_LEAD > H_TOTAL - 1) begin : g_bad_lead
    $error("video_timing_gen: FETCH_LEAD outside 1..H_TOTAL-1");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("video_timing_gen: CLK_DIV must be at least 1");
  end

  localparam logic             HS_ACT     = (HS_POL == POL_HIGH);
  localparam logic             VS_ACT     = (VS_POL == POL_HIGH);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] H_REQ      = CNT_W'(H_TOTAL - FETCH_LEAD);

  // h/v is the position the next tick will present; everything else is its registered decode
  typedef struct packed {
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             line_start;
    logic             frame_start;
    logic             line_req;
    logic [CNT_W-1:0] line_req_y;
    logic             irq;
    logic [15:0]      frame_cnt;
  } gen_state_t;

  localparam gen_state_t RESET_STATE = '{hsync: ~HS_ACT, vsync: ~VS_ACT, default: '0};

  gen_state_t r_st;
  gen_state_t w_nxt;
  logic       w_tick;
  logic       w_h_last;
  logic       w_v_last;
  logic       w_de;
  logic       w_req;

  pix_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_clk_div (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_en     (en_i),
    .o_tick   (w_tick),
    .o_pix_ce (pix_ce_o)
  );

  assign w_h_last = (r_st.h == H_LAST);
  assign w_v_last = (r_st.v == V_LAST);
  assign w_de     = (r_st.h < H_ACT) && (r_st.v < V_ACT);
  // Request on the line before each active line; the last blanking line fetches line 0
  assign w_req    = (r_st.h == H_REQ) && ((r_st.v < V_ACT_LAST) || w_v_last);

  always_comb begin
    w_nxt             = r_st;
    w_nxt.line_start  = 1'b0;
    w_nxt.frame_start = 1'b0;
    w_nxt.line_req    = 1'b0;
    if (w_tick) begin
      w_nxt.h = w_h_last ? '0 : r_st.h + 1'b1;
      if (w_h_last) begin
        w_nxt.v = w_v_last ? '0 : r_st.v + 1'b1;
      end
      w_nxt.hsync       = (r_st.h >= HS_FIRST && r_st.h <= HS_LAST) ? HS_ACT : ~HS_ACT;
      w_nxt.vsync       = (r_st.v >= VS_FIRST && r_st.v <= VS_LAST) ? VS_ACT : ~VS_ACT;
      w_nxt.de          = w_de;
      w_nxt.x           = w_de ? r_st.h : '0;
      w_nxt.y           = w_de ? r_st.v : '0;
      w_nxt.line_start  = (r_st.h == '0);
      w_nxt.frame_start = (r_st.h == '0) && (r_st.v == '0);
      w_nxt.line_req    = w_req;
      if (w_req) begin
        w_nxt.line_req_y = w_v_last ? '0 : r_st.v + 1'b1;
      end
      if (w_h_last && w_v_last) begin
        w_nxt.frame_cnt = r_st.frame_cnt + 1'b1;
      end
    end
    if (w_tick && r_st.h == '0 && r_st.v == V_ACT) begin
      w_nxt.irq = 1'b1;
    end else if (irq_clr_i) begin
      w_nxt.irq = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_st <= RESET_STATE;
    end else if (!en_i) begin
      r_st <= RESET_STATE;
    end else begin
      r_st <= w_nxt;
    end
  end

  assign hsync_o       = r_st.hsync;
  assign vsync_o       = r_st.vsync;
  assign de_o          = r_st.de;
  assign x_o           = r_st.x;
  assign y_o           = r_st.y;
  assign line_start_o  = r_st.line_start;
  assign frame_start_o = r_st.frame_start;
  assign line_req_o    = r_st.line_req;
  assign line_req_y_o  = r_st.line_req_y;
  assign vblank_irq_o  = r_st.irq;
  assign frame_cnt_o   = r_st.frame_cnt;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - random-stimulus bench for three timing configurations vs an arithmetic raster model
module tb_video_timing_gen;
  import video_pkg::*;

  logic clk = 1'b0;
  logic rst_i;
  logic en_i;
  logic irq_clr_i;

  always #5 clk = ~clk;

  // A: defaults 640x480, CLK_DIV=4
  logic ce_a, hs_a, vs_a, de_a, ls_a, fs_a, rq_a, irq_a;
  logic [9:0] x_a, y_a, ry_a;
  logic [15:0] fc_a;
  // B: 800x600, CLK_DIV=1, active-high syncs
  logic ce_b, hs_b, vs_b, de_b, ls_b, fs_b, rq_b, irq_b;
  logic [10:0] x_b, y_b, ry_b;
  logic [15:0] fc_b;
  // C: tiny frame so whole frames, vblank and frame counting are exercised
  logic ce_c, hs_c, vs_c, de_c, ls_c, fs_c, rq_c, irq_c;
  logic [3:0] x_c, y_c, ry_c;
  logic [15:0] fc_c;

  video_timing_gen u_dut_a (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .irq_clr_i(irq_clr_i),
    .pix_ce_o(ce_a), .hsync_o(hs_a), .vsync_o(vs_a), .de_o(de_a), .x_o(x_a), .y_o(y_a),
    .line_start_o(ls_a), .frame_start_o(fs_a), .line_req_o(rq_a), .line_req_y_o(ry_a),
    .vblank_irq_o(irq_a), .frame_cnt_o(fc_a)
  );

  video_timing_gen #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
    .HS_POL(POL_HIGH), .VS_POL(POL_HIGH), .CLK_DIV(1), .FETCH_LEAD(32), .CNT_W(11)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .irq_clr_i(irq_clr_i),
    .pix_ce_o(ce_b), .hsync_o(hs_b), .vsync_o(vs_b), .de_o(de_b), .x_o(x_b), .y_o(y_b),
    .line_start_o(ls_b), .frame_start_o(fs_b), .line_req_o(rq_b), .line_req_y_o(ry_b),
    .vblank_irq_o(irq_b), .frame_cnt_o(fc_b)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(POL_LOW), .VS_POL(POL_HIGH), .CLK_DIV(3), .FETCH_LEAD(4), .CNT_W(4)
  ) u_dut_c (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .irq_clr_i(irq_clr_i),
    .pix_ce_o(ce_c), .hsync_o(hs_c), .vsync_o(vs_c), .de_o(de_c), .x_o(x_c), .y_o(y_c),
    .line_start_o(ls_c), .frame_start_o(fs_c), .line_req_o(rq_c), .line_req_y_o(ry_c),
    .vblank_irq_o(irq_c), .frame_cnt_o(fc_c)
  );

  // Observed outputs, packed as {req_y, frame_cnt, irq, req, frame_start, line_start, y, x, de, vs, hs, ce}
  logic [56:0] obs_a, obs_b, obs_c;
  assign obs_a = {(rq_a ? 11'(ry_a) : 11'd0), fc_a, irq_a, rq_a, fs_a, ls_a, 11'(y_a), 11'(x_a), de_a, vs_a, hs_a, ce_a};
  assign obs_b = {(rq_b ? 11'(ry_b) : 11'd0), fc_b, irq_b, rq_b, fs_b, ls_b, 11'(y_b), 11'(x_b), de_b, vs_b, hs_b, ce_b};
  assign obs_c = {(rq_c ? 11'(ry_c) : 11'd0), fc_c, irq_c, rq_c, fs_c, ls_c, 11'(y_c), 11'(x_c), de_c, vs_c, hs_c, ce_c};

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
  endtask

  // Outputs after run-edge n: pixel index k = n/cd presents raster position k mod (ht*vt)
  function automatic logic [56:0] exp_vec(input longint ha, hf, hs, hb, va, vf, vs, vb, cd, fl,
                                          input bit hp, vp, idle, input longint n, input bit irq);
    longint ht, vt, k, p, h, v, nxt;
    bit ce, hsy, vsy, de, ls, fs, rq;
    logic [10:0] x, y, ry;
    logic [15:0] fc;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    if (idle) return {11'd0, 16'd0, 4'd0, 22'd0, 1'b0, ~vp, ~hp, 1'b0};
    k   = n / cd;
    p   = k % (ht * vt);
    h   = p % ht;
    v   = p / ht;
    ce  = (n % cd) == 0;
    hsy = (h >= ha + hf && h < ha + hf + hs) ? hp : !hp;
    vsy = (v >= va + vf && v < va + vf + vs) ? vp : !vp;
    de  = (h < ha) && (v < va);
    x   = de ? 11'(h) : 11'd0;
    y   = de ? 11'(v) : 11'd0;
    ls  = ce && h == 0;
    fs  = ls && v == 0;
    nxt = (v + 1) % vt;
    rq  = ce && h == ht - fl && nxt < va;
    ry  = rq ? 11'(nxt) : 11'd0;
    fc  = 16'((k + 1) / (ht * vt));
    return {ry, fc, irq, rq, fs, ls, y, x, de, vsy, hsy, ce};
  endfunction

  function automatic bit irq_next(input bit cur, input longint va, ht, vt, cd, n, input bit clr);
    if ((n % cd) == 0 && ((n / cd) % (ht * vt)) == va * ht) return 1'b1;
    if (clr) return 1'b0;
    return cur;
  endfunction

  int n_edges = 0;
  bit m_irq_a = 1'b0, m_irq_b = 1'b0, m_irq_c = 1'b0;

  always @(posedge clk) begin
    if (rst_i || !en_i) begin
      n_edges <= 0;
      m_irq_a <= 1'b0;
      m_irq_b <= 1'b0;
      m_irq_c <= 1'b0;
    end else begin
      n_edges <= n_edges + 1;
      m_irq_a <= irq_next(m_irq_a, 480, 800, 525, 4, longint'(n_edges), irq_clr_i);
      m_irq_b <= irq_next(m_irq_b, 600, 1056, 628, 1, longint'(n_edges), irq_clr_i);
      m_irq_c <= irq_next(m_irq_c, 6, 15, 11, 3, longint'(n_edges), irq_clr_i);
    end
  end

  task automatic compare_all();
    bit idle;
    longint n;
    idle = rst_i || (n_edges == 0);
    n    = longint'(n_edges) - 1;
    check("cfg_a_outputs", 64'(obs_a), 64'(exp_vec(640, 16, 96, 48, 480, 10, 2, 33, 4, 32, 1'b0, 1'b0, idle, n, m_irq_a)));
    check("cfg_b_outputs", 64'(obs_b), 64'(exp_vec(800, 40, 128, 88, 600, 1, 4, 23, 1, 32, 1'b1, 1'b1, idle, n, m_irq_b)));
    check("cfg_c_outputs", 64'(obs_c), 64'(exp_vec(8, 2, 3, 2, 6, 1, 2, 2, 3, 4, 1'b0, 1'b1, idle, n, m_irq_c)));
  endtask

  task automatic step(input int clr_pct);
    @(negedge clk);
    compare_all();
    irq_clr_i = ($urandom_range(99) < clr_pct);
  endtask

  int idle_ce;

  initial begin
    rst_i     = 1'b1;
    en_i      = 1'b1;
    irq_clr_i = 1'b0;
    repeat (4) step(0);
    rst_i = 1'b0;
    repeat (8000) step(25);

    en_i    = 1'b0;
    idle_ce = 0;
    repeat (1000) begin
      step(25);
      idle_ce += int'(ce_a) + int'(ce_b) + int'(ce_c);
    end
    check("idle_pix_ce_count", 64'(idle_ce), 64'd0);

    en_i = 1'b1;
    repeat (14000) step(25);

    // asynchronous reset mid-frame, checked before the next clock edge
    @(posedge clk);
    #1 rst_i = 1'b1;
    #1 compare_all();
    repeat (3) step(25);
    rst_i = 1'b0;
    repeat (9000) step(50);

    repeat (6000) begin
      step(10);
      en_i = ($urandom_range(299) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
